// File: rtl/mreq_wb_sequencer.sv
// rtl/mreq_wb_sequencer.sv - runs one granted MREQ as single Wishbone classic transfers
// Optional ack watchdog and sticky o_err: define MREQ_SEQ_TIMEOUT_EN.
module mreq_wb_sequencer #(
  parameter int ADDR_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_mreq_valid,
  output logic                 o_mreq_ready,
  input  logic                 i_mreq_wr,
  input  logic                 i_mreq_aincr,
  input  logic [1:0]           i_mreq_wsize,
  input  logic [7:0]           i_mreq_wcount,
  input  logic [ADDR_BITS-1:0] i_mreq_addr,
  input  logic                 i_wdata_valid,
  output logic                 o_wdata_ready,
  input  logic [31:0]          i_wdata,
  output logic                 o_rdata_valid,
  input  logic                 i_rdata_ready,
  output logic [31:0]          o_rdata,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic [ADDR_BITS-3:0] o_wb_adr,
  output logic [3:0]           o_wb_sel,
  output logic [31:0]          o_wb_dat,
  input  logic [31:0]          i_wb_dat,
  input  logic                 i_wb_ack,
  output logic                 o_busy,
  output logic                 o_err
);

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_BUS, S_RDATA} state_t;

  state_t               state;
  logic                 wr_q;
  logic                 aincr_q;
  logic [1:0]           wsize_q;
  logic [7:0]           rem_q;
  logic [ADDR_BITS-1:0] addr_q;

  logic [ADDR_BITS-1:0] req_addr;
  logic [ADDR_BITS-1:0] addr_step;
  logic [ADDR_BITS-1:0] addr_next;
  logic [31:0]          wr_shift;
  logic [31:0]          rd_shift;
  logic [31:0]          rd_lane;

  function automatic logic [3:0] lane_sel(input logic [1:0] lo, input logic [1:0] sz);
    logic [3:0] s;
    case (sz)
      2'd0:    s = 4'b0001 << lo;
      2'd1:    s = 4'b0011 << lo;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Force the request address onto a natural boundary for its size.
  always_comb begin
    req_addr = i_mreq_addr;
    if (i_mreq_wsize == 2'd1)
      req_addr[0] = 1'b0;
    else if (i_mreq_wsize[1])
      req_addr[1:0] = 2'b00;
  end

  always_comb begin
    case (wsize_q)
      2'd0:    addr_step = ADDR_BITS'(1);
      2'd1:    addr_step = ADDR_BITS'(2);
      default: addr_step = ADDR_BITS'(4);
    endcase
    addr_next = aincr_q ? addr_q + addr_step : addr_q;
  end

  always_comb begin
    wr_shift = i_wdata << {addr_q[1:0], 3'b000};
    rd_shift = i_wb_dat >> {addr_q[1:0], 3'b000};
    case (wsize_q)
      2'd0:    rd_lane = {24'h000000, rd_shift[7:0]};
      2'd1:    rd_lane = {16'h0000, rd_shift[15:0]};
      default: rd_lane = rd_shift;
    endcase
  end

`ifdef MREQ_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign o_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wr_q          <= 1'b0;
      aincr_q       <= 1'b0;
      wsize_q       <= 2'd0;
      rem_q         <= 8'd0;
      addr_q        <= '0;
      o_mreq_ready  <= 1'b1;
      o_wdata_ready <= 1'b0;
      o_rdata_valid <= 1'b0;
      o_rdata       <= 32'h0;
      o_wb_cyc      <= 1'b0;
      o_wb_stb      <= 1'b0;
      o_wb_we       <= 1'b0;
      o_wb_adr      <= '0;
      o_wb_sel      <= 4'h0;
      o_wb_dat      <= 32'h0;
      o_busy        <= 1'b0;
`ifdef MREQ_SEQ_TIMEOUT_EN
      tmo_cnt       <= '0;
      o_err         <= 1'b0;
`endif
    end else begin
`ifdef MREQ_SEQ_TIMEOUT_EN
      if (state != S_BUS)
        tmo_cnt <= '0;
`endif
      case (state)
        S_IDLE: begin
          if (i_mreq_valid) begin
            wr_q         <= i_mreq_wr;
            aincr_q      <= i_mreq_aincr;
            wsize_q      <= i_mreq_wsize;
            rem_q        <= i_mreq_wcount;
            addr_q       <= req_addr;
            o_mreq_ready <= 1'b0;
            o_busy       <= 1'b1;
            if (i_mreq_wr) begin
              state         <= S_WDATA;
              o_wdata_ready <= 1'b1;
            end else begin
              state    <= S_BUS;
              o_wb_cyc <= 1'b1;
              o_wb_stb <= 1'b1;
              o_wb_we  <= 1'b0;
              o_wb_adr <= req_addr[ADDR_BITS-1:2];
              o_wb_sel <= lane_sel(req_addr[1:0], i_mreq_wsize);
            end
          end
        end

        S_WDATA: begin
          if (i_wdata_valid) begin
            o_wdata_ready <= 1'b0;
            o_wb_dat      <= wr_shift;
            state         <= S_BUS;
            o_wb_cyc      <= 1'b1;
            o_wb_stb      <= 1'b1;
            o_wb_we       <= 1'b1;
            o_wb_adr      <= addr_q[ADDR_BITS-1:2];
            o_wb_sel      <= lane_sel(addr_q[1:0], wsize_q);
          end
        end

        S_BUS: begin
          if (i_wb_ack) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
            if (wr_q) begin
              if (rem_q == 8'd0) begin
                state        <= S_IDLE;
                o_mreq_ready <= 1'b1;
                o_busy       <= 1'b0;
              end else begin
                rem_q         <= rem_q - 8'd1;
                addr_q        <= addr_next;
                state         <= S_WDATA;
                o_wdata_ready <= 1'b1;
              end
            end else begin
              o_rdata       <= rd_lane;
              o_rdata_valid <= 1'b1;
              state         <= S_RDATA;
            end
          end
`ifdef MREQ_SEQ_TIMEOUT_EN
          // Watchdog expiry abandons the rest of the request.
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            o_wb_cyc     <= 1'b0;
            o_wb_stb     <= 1'b0;
            o_wb_we      <= 1'b0;
            o_err        <= 1'b1;
            state        <= S_IDLE;
            o_mreq_ready <= 1'b1;
            o_busy       <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end

        S_RDATA: begin
          if (i_rdata_ready) begin
            o_rdata_valid <= 1'b0;
            if (rem_q == 8'd0) begin
              state        <= S_IDLE;
              o_mreq_ready <= 1'b1;
              o_busy       <= 1'b0;
            end else begin
              rem_q    <= rem_q - 8'd1;
              addr_q   <= addr_next;
              state    <= S_BUS;
              o_wb_cyc <= 1'b1;
              o_wb_stb <= 1'b1;
              o_wb_we  <= 1'b0;
              o_wb_adr <= addr_next[ADDR_BITS-1:2];
              o_wb_sel <= lane_sel(addr_next[1:0], wsize_q);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
